// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO; one bit per clock.
// Optional MUL_DIV_SIGNED_EN enables signed MULT/DIV handling.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iWrHi,
  input  logic             iWrLo,
  input  logic [WIDTH-1:0] iWData,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo
);

`ifdef MUL_DIV_SIGNED_EN
  localparam logic SignedEn = 1'b1;
`else
  localparam logic SignedEn = 1'b0;
`endif

  localparam int CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    ZERO
  } state_t;

  state_t state;
  state_t nextState;

  logic [CntW-1:0]  cnt;
  logic             isDiv;
  logic             sA;
  logic             sB;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  logic             signedOp;
  logic             negA;
  logic             negB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             startDivZero;

  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  // Operand conditioning at start: signs and magnitudes
  always_comb begin
    signedOp     = iOp[0] & SignedEn;
    negA         = signedOp & iA[WIDTH-1];
    negB         = signedOp & iB[WIDTH-1];
    magA         = negA ? (~iA + 1'b1) : iA;
    magB         = negB ? (~iB + 1'b1) : iB;
    startDivZero = iOp[1] && (iB == '0);
  end

  // One iteration step and the sign fix-up of the final result
  always_comb begin
    mulSum   = {1'b0, accHi}
             + ({1'b0, opnd} & {(WIDTH+1){accLo[0]}});
    divTrial = {accHi, accLo[WIDTH-1]} - {1'b0, opnd};
    prod     = {accHi, accLo};
    prodFix  = (sA ^ sB) ? (~prod + 1'b1) : prod;
    quoFix   = (sA ^ sB) ? (~accLo + 1'b1) : accLo;
    remFix   = sA ? (~accHi + 1'b1) : accHi;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (iStart) nextState = startDivZero ? ZERO : RUN;
      end
      RUN: begin
        if (cnt == LastCnt) nextState = FIX;
      end
      FIX:     nextState = IDLE;
      ZERO:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand latch and iterative shift-add / restoring-divide datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      isDiv <= 1'b0;
      sA    <= 1'b0;
      sB    <= 1'b0;
      opnd  <= '0;
      accHi <= '0;
      accLo <= '0;
    end else if (state == IDLE) begin
      if (iStart) begin
        cnt   <= '0;
        isDiv <= iOp[1];
        sA    <= negA;
        sB    <= negB;
        opnd  <= iOp[1] ? magB : magA;
        accHi <= '0;
        accLo <= iOp[1] ? magA : magB;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (isDiv) begin
        if (!divTrial[WIDTH]) begin
          accHi <= divTrial[WIDTH-1:0];
          accLo <= {accLo[WIDTH-2:0], 1'b1};
        end else begin
          accHi <= {accHi[WIDTH-2:0], accLo[WIDTH-1]};
          accLo <= {accLo[WIDTH-2:0], 1'b0};
        end
      end else begin
        accHi <= mulSum[WIDTH:1];
        accLo <= {mulSum[0], accLo[WIDTH-1:1]};
      end
    end
  end

  // HI/LO registers: MTHI/MTLO in IDLE, results at FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (state == IDLE) begin
      if (iWrHi) hiReg <= iWData;
      if (iWrLo) loReg <= iWData;
    end else if (state == FIX) begin
      if (isDiv) begin
        hiReg <= remFix;
        loReg <= quoFix;
      end else begin
        hiReg <= prodFix[2*WIDTH-1:WIDTH];
        loReg <= prodFix[WIDTH-1:0];
      end
    end
  end

  // Completion pulses, raised on the edge that leaves FIX or ZERO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oDone    <= 1'b0;
      oDivZero <= 1'b0;
    end else begin
      oDone    <= (state == FIX) || (state == ZERO);
      oDivZero <= (state == ZERO);
    end
  end

  assign oBusy = (state != IDLE);
  assign oHi   = hiReg;
  assign oLo   = loReg;

endmodule
